// File: rtl/clas_pipe_if.sv
// Operand/result handshake bundle for clas_pipe.
// The master drives operands and out_ready; the slave is the adder pipe.
interface clas_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, sel, a, b, out_ready,
    input  in_ready, out_valid, result, c_out, ovf, zero, neg
  );

  modport slave (
    input  in_valid, sel, a, b, out_ready,
    output in_ready, out_valid, result, c_out, ovf, zero, neg
  );
endinterface

// File: rtl/clas_pipe.sv
// Pipelined CLA add/sub: 4-bit CLA slices, carry registered every SLICES_PER_STAGE slices.
// Define CLAS_FLAGS_EN to generate the ovf/zero/neg status flags (tied to 0 otherwise).
module clas_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:1] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & ci);
  assign s    = p ^ {c[3:1], ci};
endmodule

module clas_pipe #(
  parameter int WIDTH            = 32,
  parameter int SLICES_PER_STAGE = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  clas_pipe_if.slave  io
);
  localparam int GW     = 4 * SLICES_PER_STAGE;
  localparam int STAGES = WIDTH / GW;

  logic             advance;
  logic [WIDTH-1:0] b_x;

  // Stalls are global: the whole pipe, bubbles included, freezes together.
  assign advance     = !io.out_valid || io.out_ready;
  assign io.in_ready = advance;
  assign b_x         = io.b ^ {WIDTH{io.sel}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unconsumed after this stage
    localparam int REM = WIDTH - (k + 1) * GW;

    logic [GW-1:0]             a_g, bx_g, s_g;
    logic                      ci_g, vi;
    logic [SLICES_PER_STAGE:0] cc;
    logic [(k+1)*GW-1:0]       sum_d, sum_q;
    logic                      v_q, c_q;

    if (k == 0) begin : g_in
      assign a_g   = io.a[GW-1:0];
      assign bx_g  = b_x[GW-1:0];
      assign ci_g  = io.sel;
      assign vi    = io.in_valid;
      assign sum_d = s_g;
    end else begin : g_in
      assign a_g   = g_stage[k-1].g_rem.a_q[GW-1:0];
      assign bx_g  = g_stage[k-1].g_rem.bx_q[GW-1:0];
      assign ci_g  = g_stage[k-1].c_q;
      assign vi    = g_stage[k-1].v_q;
      assign sum_d = {s_g, g_stage[k-1].sum_q};
    end

    assign cc[0] = ci_g;
    for (genvar j = 0; j < SLICES_PER_STAGE; j++) begin : g_slice
      clas_slice u_slice (
        .a  (a_g[4*j +: 4]),
        .b  (bx_g[4*j +: 4]),
        .ci (cc[j]),
        .s  (s_g[4*j +: 4]),
        .co (cc[j+1])
      );
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= vi;
        c_q   <= cc[SLICES_PER_STAGE];
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [REM-1:0] a_d, bx_d, a_q, bx_q;

      if (k == 0) begin : g_src
        assign a_d  = io.a[WIDTH-1:GW];
        assign bx_d = b_x[WIDTH-1:GW];
      end else begin : g_src
        assign a_d  = g_stage[k-1].g_rem.a_q[REM+GW-1:GW];
        assign bx_d = g_stage[k-1].g_rem.bx_q[REM+GW-1:GW];
      end

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (advance) begin
          a_q  <= a_d;
          bx_q <= bx_d;
        end
      end
    end
  end

  assign io.out_valid = g_stage[STAGES-1].v_q;
  assign io.result    = g_stage[STAGES-1].sum_q;
  assign io.c_out     = g_stage[STAGES-1].c_q;

`ifdef CLAS_FLAGS_EN
  logic msb_ci_q;

  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c_in.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      msb_ci_q <= 1'b0;
    else if (advance)
      msb_ci_q <= g_stage[STAGES-1].a_g[GW-1] ^ g_stage[STAGES-1].bx_g[GW-1]
                ^ g_stage[STAGES-1].s_g[GW-1];
  end

  assign io.ovf  = msb_ci_q ^ io.c_out;
  assign io.zero = ~|io.result;
  assign io.neg  = io.result[WIDTH-1];
`else
  assign io.ovf  = 1'b0;
  assign io.zero = 1'b0;
  assign io.neg  = 1'b0;
`endif
endmodule

// File: tb/tb_clas_pipe.sv
// Randomized bench for clas_pipe against an arithmetic reference model (WIDTH=32, 4 stages).
module tb_clas_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef CLAS_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        c, ovf, zero, neg;
    int unsigned acc;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  clas_pipe_if #(.WIDTH(WIDTH)) io ();
  clas_pipe #(.WIDTH(WIDTH), .SLICES_PER_STAGE(2)) dut (.clk(clk), .n_rst(n_rst), .io(io));

  int          checks = 0, fails = 0;
  int unsigned cyc = 0;
  int          n_out = 0;
  exp_t        q[$];
  bit          lat_exact = 1'b0, prev_stall = 1'b0, ov_s, ir_s, acc_s;
  logic [31:0] prev_res, last_res;
  logic        prev_c, last_c, last_ovf, last_zero, last_neg;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sel,
                                 input int unsigned acc);
    exp_t        e;
    logic [32:0] u;
    longint      sr;
    if (sel) begin
      e.res = a - b;
      e.c   = (a >= b);
      sr    = longint'($signed(a)) - longint'($signed(b));
    end else begin
      u     = {1'b0, a} + {1'b0, b};
      e.res = u[31:0];
      e.c   = u[32];
      sr    = longint'($signed(a)) + longint'($signed(b));
    end
    e.ovf  = FL && (sr != longint'($signed(e.res)));
    e.zero = FL && (e.res == 32'd0);
    e.neg  = FL && e.res[31];
    e.acc  = acc;
    return e;
  endfunction

  // One clock: sample at negedge, then return #1 after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", io.out_valid, 1);
      chk("hold_result", io.result, prev_res);
      chk("hold_c_out", io.c_out, prev_c);
    end
    prev_stall = io.out_valid && !io.out_ready;
    if (prev_stall) begin
      prev_res = io.result;
      prev_c   = io.c_out;
      chk("stall_in_ready", io.in_ready, 0);
    end
    ov_s  = io.out_valid;
    ir_s  = io.in_ready;
    acc_s = io.in_valid && io.in_ready;
    if (io.out_valid && io.out_ready) begin
      if (q.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", io.result, e.res);
        chk("c_out", io.c_out, e.c);
        chk("ovf", io.ovf, e.ovf);
        chk("zero", io.zero, e.zero);
        chk("neg", io.neg, e.neg);
        if (lat_exact) chk("latency", cyc - e.acc, STAGES);
        last_res = io.result; last_c = io.c_out;
        last_ovf = io.ovf; last_zero = io.zero; last_neg = io.neg;
        n_out++;
      end
    end
    if (acc_s) q.push_back(model(io.a, io.b, io.sel, cyc));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sel, input logic [31:0] er, input logic ec,
                         input logic eo, input logic ez, input logic en);
    int n0;
    io.in_valid = 1'b1; io.a = a; io.b = b; io.sel = sel;
    n0 = n_out;
    cycle();
    io.in_valid = 1'b0;
    for (int i = 0; i < 12 && n_out == n0; i++) cycle();
    chk({tag, "_done"}, n_out - n0, 1);
    chk({tag, "_res"}, last_res, er);
    chk({tag, "_c"}, last_c, ec);
    chk({tag, "_ovf"}, last_ovf, eo & FL);
    chk({tag, "_zero"}, last_zero, ez & FL);
    chk({tag, "_neg"}, last_neg, en & FL);
  endtask

  initial begin
    int sent, stall_cnt, n0;
    bit bp_done;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.sel = 1'b0; io.out_ready = 1'b1;
    #3;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_result", io.result, 0);
    chk("rst_c_out", io.c_out, 0);
    chk("rst_zero", io.zero, FL);
    chk("rst_ovf", io.ovf, 0);
    chk("rst_in_ready", io.in_ready, 1);
    @(posedge clk); #1 n_rst = 1'b1;

    lat_exact = 1'b1;
    run_one("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("borrow", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_one("ovf_sub", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream: output continuous from the 4th cycle on.
    for (int i = 0; i < 104; i++) begin
      io.in_valid = (i < 100);
      io.a = $urandom; io.b = $urandom; io.sel = 1'($urandom_range(0, 1));
      if (i % 16 == 3) io.b = io.a;
      cycle();
      chk("stream_in_ready", ir_s, 1);
      if (i >= STAGES) chk("stream_out_valid", ov_s, 1);
    end
    lat_exact = 1'b0;

    // Eight beats with a 3-cycle consumer stall once output appears.
    sent = 0; stall_cnt = 0; bp_done = 1'b0; n0 = n_out;
    for (int i = 0; i < 30; i++) begin
      if (!bp_done && io.out_valid) begin
        io.out_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt == 3) bp_done = 1'b1;
      end else io.out_ready = 1'b1;
      io.in_valid = (sent < 8);
      io.a = $urandom; io.b = $urandom; io.sel = 1'($urandom_range(0, 1));
      cycle();
      if (acc_s) sent++;
    end
    chk("bp_stalls", stall_cnt, 3);
    chk("bp_beats", n_out - n0, 8);

    // Random valid/ready mix, then drain.
    for (int i = 0; i < 60; i++) begin
      io.out_ready = (i >= 50) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      io.in_valid  = (i < 50) && ($urandom_range(0, 2) != 0);
      io.a = $urandom; io.b = $urandom; io.sel = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("drain_empty", q.size(), 0);

    // Reset with three beats in flight.
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io.in_valid = 1'b1; io.a = $urandom | 32'h1; io.b = $urandom; io.sel = 1'b0;
      cycle();
    end
    n_rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", io.out_valid, 0);
    chk("mid_rst_result", io.result, 0);
    chk("mid_rst_in_ready", io.in_ready, 1);
    q.delete();
    prev_stall = 1'b0;
    io.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    lat_exact = 1'b1;
    run_one("post_rst", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) cycle();
    chk("final_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
